// File: rtl/servo_pkg.sv
// Shared encodings for the servo sweep sequencer: channel modes, channel
// states and the reset/centre angle helper.
package servo_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD    = 2'd0,
    MODE_BOUNCE  = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_HOME    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_UP     = 2'd1,
    ST_DOWN   = 2'd2,
    ST_PARKED = 2'd3
  } state_e;

  // Centre code of an angle bus, i.e. 0 degrees.
  function automatic int angle_centre(input int angle_w);
    return 1 << (angle_w - 1);
  endfunction

endpackage

// File: rtl/servo_sweep_ch.sv
// One servo channel: PWM-period divider, sweep FSM and bounded step arithmetic.
// The FSM state is brought out so the top can derive busy and checkers can bind to it.
module servo_sweep_ch
  import servo_pkg::*;
#(
  parameter int ANGLE_W = 8,
  parameter int STEP_W  = 4,
  parameter int DIV_W   = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cycle_done,
  input  logic               move_en,
  input  logic [1:0]         mode,
  input  logic [ANGLE_W-1:0] start_angle,
  input  logic [ANGLE_W-1:0] end_angle,
  input  logic [STEP_W-1:0]  step,
  input  logic [DIV_W-1:0]   div,
  output logic [ANGLE_W-1:0] angle,
  output logic               edge_hit,
  output state_e             state
);

  localparam logic [ANGLE_W-1:0] CENTRE = ANGLE_W'(angle_centre(ANGLE_W));

  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic               dir_up_q, dir_up_d;
  logic [DIV_W-1:0]   cnt_q;
  state_e             state_q, state_d;
  mode_e              last_mode_q, last_mode_d;
  logic               edge_q, edge_d;

  logic               step_ev;
  mode_e              m;
  logic [ANGLE_W:0]   a_ext, s_ext, e_ext, st_ext, up_sum, up_val, dn_val, nxt;
  logic               go_up, hit_start, hit_end;

  assign step_ev = cycle_done && (cnt_q >= div);
  assign m       = mode_e'(mode);
  assign a_ext   = {1'b0, angle_q};
  assign s_ext   = {1'b0, start_angle};
  assign e_ext   = {1'b0, end_angle};
  assign st_ext  = (ANGLE_W+1)'(step);
  assign up_sum  = a_ext + st_ext;
  assign up_val  = (up_sum > e_ext) ? e_ext : up_sum;
  // a - step < start is tested as a < start + step so nothing can underflow.
  assign dn_val  = (a_ext < s_ext + st_ext) ? s_ext : a_ext - st_ext;

  always_comb begin
    angle_d     = angle_q;
    dir_up_d    = dir_up_q;
    state_d     = state_q;
    last_mode_d = last_mode_q;
    edge_d      = 1'b0;
    go_up       = 1'b0;
    hit_start   = 1'b0;
    hit_end     = 1'b0;
    nxt         = a_ext;
    if (step_ev && move_en) begin
      last_mode_d = m;
      if ((start_angle > end_angle) || (m == MODE_HOLD) || (step == '0)) begin
        state_d = ST_HOLD;
      end else if ((state_q == ST_PARKED) && (m == last_mode_q) && (m != MODE_BOUNCE)) begin
        state_d = ST_PARKED;
      end else if (start_angle == end_angle) begin
        if (!((state_q == ST_PARKED) && (angle_q == start_angle))) begin
          angle_d = start_angle;
          edge_d  = 1'b1;
        end
        state_d = ST_PARKED;
      end else begin
        if (angle_q < start_angle) begin
          angle_d   = start_angle;
          hit_start = 1'b1;
        end else if (angle_q > end_angle) begin
          angle_d = end_angle;
          hit_end = 1'b1;
        end else begin
          go_up     = (m == MODE_ONESHOT) || ((m == MODE_BOUNCE) && dir_up_q);
          nxt       = go_up ? up_val : dn_val;
          angle_d   = nxt[ANGLE_W-1:0];
          hit_end   = go_up && (nxt == e_ext);
          hit_start = !go_up && (nxt == s_ext);
        end
        edge_d = hit_start || hit_end;
        case (m)
          MODE_BOUNCE: begin
            dir_up_d = hit_end ? 1'b0 : (hit_start ? 1'b1 : dir_up_q);
            state_d  = dir_up_d ? ST_UP : ST_DOWN;
          end
          MODE_ONESHOT: begin
            dir_up_d = 1'b1;
            state_d  = hit_end ? ST_PARKED : ST_UP;
          end
          MODE_HOME: begin
            dir_up_d = 1'b0;
            state_d  = hit_start ? ST_PARKED : ST_DOWN;
          end
          default: state_d = ST_HOLD;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      angle_q     <= CENTRE;
      dir_up_q    <= 1'b1;
      cnt_q       <= '0;
      state_q     <= ST_HOLD;
      last_mode_q <= MODE_HOLD;
      edge_q      <= 1'b0;
    end else begin
      angle_q     <= angle_d;
      dir_up_q    <= dir_up_d;
      state_q     <= state_d;
      last_mode_q <= last_mode_d;
      edge_q      <= edge_d;
      if (cycle_done) cnt_q <= step_ev ? '0 : cnt_q + 1'b1;
    end
  end

  assign angle    = angle_q;
  assign edge_hit = edge_q;
  assign state    = state_q;

endmodule

// File: rtl/servo_sweep_ctrl.sv
// Multi-channel servo angle sequencer: slices the flat control buses into
// independent servo_sweep_ch instances.
module servo_sweep_ctrl
  import servo_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int ANGLE_W = 8,
  parameter int STEP_W  = 4,
  parameter int DIV_W   = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         servo_cycle_done,
  output logic [NUM_CH*ANGLE_W-1:0] servo_angle,
  input  logic [NUM_CH-1:0]         move_en,
  input  logic [NUM_CH*2-1:0]       mode,
  input  logic [NUM_CH*ANGLE_W-1:0] start_angle,
  input  logic [NUM_CH*ANGLE_W-1:0] end_angle,
  input  logic [NUM_CH*STEP_W-1:0]  step,
  input  logic [NUM_CH*DIV_W-1:0]   div,
  output logic [NUM_CH-1:0]         edge_hit,
  output logic [NUM_CH-1:0]         busy
);

  state_e ch_state [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_sweep_ch #(
      .ANGLE_W(ANGLE_W),
      .STEP_W (STEP_W),
      .DIV_W  (DIV_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .cycle_done (servo_cycle_done[i]),
      .move_en    (move_en[i]),
      .mode       (mode[i*2 +: 2]),
      .start_angle(start_angle[i*ANGLE_W +: ANGLE_W]),
      .end_angle  (end_angle[i*ANGLE_W +: ANGLE_W]),
      .step       (step[i*STEP_W +: STEP_W]),
      .div        (div[i*DIV_W +: DIV_W]),
      .angle      (servo_angle[i*ANGLE_W +: ANGLE_W]),
      .edge_hit   (edge_hit[i]),
      .state      (ch_state[i])
    );

    // Parked and held channels are idle; only active sweeping counts as busy.
    assign busy[i] = (ch_state[i] == ST_UP) || (ch_state[i] == ST_DOWN);
  end

endmodule

// File: tb/tb_servo_sweep_ctrl.sv
// Directed bench for servo_sweep_ctrl: hand-computed angle, edge_hit and busy
// values after each servo_cycle_done pulse.
module tb_servo_sweep_ctrl;

  localparam int NUM_CH  = 4;
  localparam int ANGLE_W = 8;
  localparam int STEP_W  = 4;
  localparam int DIV_W   = 9;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_CH-1:0]         servo_cycle_done = '0;
  logic [NUM_CH*ANGLE_W-1:0] servo_angle;
  logic [NUM_CH-1:0]         move_en = '1;
  logic [NUM_CH*2-1:0]       mode = '0;
  logic [NUM_CH*ANGLE_W-1:0] start_angle = '0;
  logic [NUM_CH*ANGLE_W-1:0] end_angle = '1;
  logic [NUM_CH*STEP_W-1:0]  step = '0;
  logic [NUM_CH*DIV_W-1:0]   div = '0;
  logic [NUM_CH-1:0]         edge_hit;
  logic [NUM_CH-1:0]         busy;

  int checks = 0;
  int errors = 0;

  servo_sweep_ctrl #(
    .NUM_CH(NUM_CH), .ANGLE_W(ANGLE_W), .STEP_W(STEP_W), .DIV_W(DIV_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .servo_cycle_done(servo_cycle_done),
    .servo_angle     (servo_angle),
    .move_en         (move_en),
    .mode            (mode),
    .start_angle     (start_angle),
    .end_angle       (end_angle),
    .step            (step),
    .div             (div),
    .edge_hit        (edge_hit),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [1:0] m, input logic [7:0] s,
                        input logic [7:0] e, input logic [3:0] st, input logic [8:0] d);
    mode[ch*2 +: 2]               = m;
    start_angle[ch*ANGLE_W +: 8]  = s;
    end_angle[ch*ANGLE_W +: 8]    = e;
    step[ch*STEP_W +: 4]          = st;
    div[ch*DIV_W +: 9]            = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    servo_cycle_done = '0;
    move_en = '1;
    mode = '0;
    start_angle = '0;
    end_angle = '1;
    step = '0;
    div = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One done pulse roughly every 8 clocks; returns on the negedge after the update edge.
  task automatic pulse(input logic [NUM_CH-1:0] mask);
    repeat (6) @(negedge clk);
    servo_cycle_done = mask;
    @(negedge clk);
    servo_cycle_done = '0;
  endtask

  function automatic logic [7:0] ang(input int ch);
    return servo_angle[ch*ANGLE_W +: 8];
  endfunction

  initial begin
    // Power-on reset state
    repeat (2) @(negedge clk);
    check("por_angle", servo_angle, 32'h80808080);
    check("por_busy", busy, 4'h0);
    check("por_edge", edge_hit, 4'h0);

    // 1. Reset mid-sweep, asynchronously
    do_reset();
    set_ch(0, 2'd1, 8'h80, 8'h90, 4'd8, 9'd0);
    pulse(4'h1);
    check("t1_a0_step1", ang(0), 8'h88);
    check("t1_busy_step1", busy, 4'h1);
    pulse(4'h1);
    check("t1_a0_step2", ang(0), 8'h90);
    check("t1_edge_step2", edge_hit, 4'h1);
    #2 rst = 1'b1;
    #1;
    check("t1_async_angle", servo_angle, 32'h80808080);
    check("t1_async_busy", busy, 4'h0);
    check("t1_async_edge", edge_hit, 4'h0);

    // 2. BOUNCE between 0x7C and 0x84
    do_reset();
    set_ch(0, 2'd1, 8'h7C, 8'h84, 4'd4, 9'd0);
    pulse(4'h1);
    check("t2_a_84", ang(0), 8'h84);
    check("t2_edge_84", edge_hit, 4'h1);
    pulse(4'h1);
    check("t2_a_80", ang(0), 8'h80);
    check("t2_edge_80", edge_hit, 4'h0);
    check("t2_busy_down", busy, 4'h1);
    pulse(4'h1);
    check("t2_a_7c", ang(0), 8'h7C);
    check("t2_edge_7c", edge_hit, 4'h1);
    pulse(4'h1);
    check("t2_a_80_up", ang(0), 8'h80);
    check("t2_edge_80_up", edge_hit, 4'h0);

    // 3. ONESHOT climbs, clamps at end, parks
    do_reset();
    set_ch(1, 2'd2, 8'h80, 8'h86, 4'd4, 9'd0);
    pulse(4'h2);
    check("t3_a_84", ang(1), 8'h84);
    check("t3_edge_84", edge_hit, 4'h0);
    check("t3_busy_84", busy, 4'h2);
    pulse(4'h2);
    check("t3_a_86", ang(1), 8'h86);
    check("t3_edge_86", edge_hit, 4'h2);
    check("t3_busy_parked", busy, 4'h0);
    pulse(4'h2);
    check("t3_a_parked", ang(1), 8'h86);
    check("t3_edge_parked", edge_hit, 4'h0);

    // 4. Divider cadence with a skipped step
    do_reset();
    set_ch(2, 2'd1, 8'h70, 8'h90, 4'd1, 9'd2);
    pulse(4'h4);
    pulse(4'h4);
    check("t4_a_p2", ang(2), 8'h80);
    pulse(4'h4);
    check("t4_a_p3", ang(2), 8'h81);
    pulse(4'h4);
    pulse(4'h4);
    move_en = 4'hB;
    pulse(4'h4);
    check("t4_a_skip", ang(2), 8'h81);
    move_en = 4'hF;
    pulse(4'h4);
    pulse(4'h4);
    check("t4_a_p8", ang(2), 8'h81);
    pulse(4'h4);
    check("t4_a_p9", ang(2), 8'h82);

    // 5. Bounds moved above the angle: clamp to start, then climb
    do_reset();
    set_ch(3, 2'd1, 8'h90, 8'hA0, 4'd4, 9'd0);
    pulse(4'h8);
    check("t5_a_clamp", ang(3), 8'h90);
    check("t5_edge_clamp", edge_hit, 4'h8);
    pulse(4'h8);
    check("t5_a_up", ang(3), 8'h94);
    check("t5_edge_up", edge_hit, 4'h0);
    check("t5_busy_up", busy, 4'h8);

    // 6. All channels step in the same clock with different modes
    do_reset();
    set_ch(0, 2'd1, 8'h7C, 8'h84, 4'd4, 9'd0);
    set_ch(1, 2'd2, 8'h80, 8'h86, 4'd4, 9'd0);
    set_ch(2, 2'd3, 8'h78, 8'h90, 4'd8, 9'd0);
    set_ch(3, 2'd0, 8'h70, 8'h90, 4'd4, 9'd0);
    pulse(4'hF);
    check("t6_angles", servo_angle, 32'h80788484);
    check("t6_edge", edge_hit, 4'h5);
    check("t6_busy", busy, 4'h3);

    // start == end parks once; start > end is ignored
    do_reset();
    set_ch(0, 2'd1, 8'h70, 8'h70, 4'd4, 9'd0);
    set_ch(1, 2'd1, 8'h90, 8'h80, 4'd4, 9'd0);
    pulse(4'h3);
    check("eq_a0", ang(0), 8'h70);
    check("inv_a1", ang(1), 8'h80);
    check("eq_inv_edge", edge_hit, 4'h1);
    check("eq_inv_busy", busy, 4'h0);
    pulse(4'h3);
    check("eq_a0_again", ang(0), 8'h70);
    check("eq_edge_again", edge_hit, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
